// File: rtl/fp_accum_driver.sv
// fp_accum_driver: streams FP32 elements through a strobe/ack adder, accumulating a per-vector sum.
// Optional FP_ACC_SKIP_ZERO_EN: accepted +/-0 elements bypass the adder round trip.
module fp_accum_driver #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic             add_a_stb,
    input  logic             add_a_ack,
    output logic [31:0]      add_b,
    output logic             add_b_stb,
    input  logic             add_b_ack,
    input  logic [31:0]      add_z,
    input  logic             add_z_stb,
    output logic             add_z_ack,
    output logic [31:0]      sum_data,
    output logic [CNT_W-1:0] sum_count,
    output logic             sum_valid,
    input  logic             sum_ready
);
    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, OUT} state_t;
    state_t           state_q;
    logic [31:0]      acc_q, elem_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;
    assign in_ready  = state_q == IDLE;
    assign add_a_stb = state_q == SEND_A;
    assign add_b_stb = state_q == SEND_B;
    assign add_z_ack = state_q == WAIT_Z;
    assign sum_valid = state_q == OUT;
    assign add_a     = acc_q;
    assign add_b     = elem_q;
    assign sum_data  = acc_q;
    assign sum_count = cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            elem_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    elem_q <= in_data;
                    last_q <= in_last;
                    cnt_q  <= &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
`ifdef FP_ACC_SKIP_ZERO_EN
                    // acc never holds -0, so skipping a signed zero matches the adder's +0 result
                    state_q <= in_data[30:0] == '0 ? (in_last ? OUT : IDLE) : SEND_A;
`else
                    state_q <= SEND_A;
`endif
                end
                SEND_A: if (add_a_ack) state_q <= SEND_B;
                SEND_B: if (add_b_ack) state_q <= WAIT_Z;
                WAIT_Z: if (add_z_stb) begin
                    acc_q   <= add_z;
                    state_q <= last_q ? OUT : IDLE;
                end
                OUT: if (sum_ready) begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_accum_driver.sv
// tb_fp_accum_driver: directed vectors against a table-driven adder responder.
module tb_fp_accum_driver;
    localparam int CW = 2;
    logic clk = 0, rst = 1;
    logic [31:0] in_data = 0;
    logic in_last = 0, in_valid = 0, in_ready;
    logic [31:0] add_a, add_b, add_z;
    logic add_a_stb, add_b_stb, add_z_ack, add_z_stb;
    logic add_a_ack = 1, add_b_ack = 1;
    logic [31:0] sum_data;
    logic [CW-1:0] sum_count;
    logic sum_valid, sum_ready = 0;
    int n = 0, err = 0;
    int a_cnt = 0, b_cnt = 0, lat = 0;
    logic [31:0] a_v = 0, zval = 0;
    logic z_q = 0, spur = 0;

    always #5 clk = ~clk;

    fp_accum_driver #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
        .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
        .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .sum_data(sum_data), .sum_count(sum_count), .sum_valid(sum_valid), .sum_ready(sum_ready)
    );

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h00000000, 32'h3F800000}: return 32'h3F800000;
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40400000, 32'h40400000}: return 32'h40C00000;
            {32'h00000000, 32'hC0490FDB}: return 32'hC0490FDB;
            {32'h3F800000, 32'hBF800000}: return 32'h00000000;
            {32'h00000000, 32'h40000000}: return 32'h40000000;
            {32'h00000000, 32'h00000000}: return 32'h00000000;
            {32'h00000000, 32'h80000000}: return 32'h00000000;
            default:                      return 32'hFFFFFFFF;
        endcase
    endfunction

    assign add_z_stb = z_q | spur;
    assign add_z     = spur ? 32'hDEADBEEF : zval;

    // Adder responder: result strobe appears a few cycles after operand B
    always @(posedge clk) begin
        if (rst) begin
            z_q <= 0;
            lat <= 0;
        end else begin
            if (add_a_stb && add_a_ack) begin
                a_cnt <= a_cnt + 1;
                a_v   <= add_a;
            end
            if (add_b_stb && add_b_ack) begin
                b_cnt <= b_cnt + 1;
                zval  <= fadd(a_v, add_b);
                lat   <= 3;
            end else if (lat != 0) lat <= lat - 1;
            if (add_z_stb && add_z_ack) z_q <= 0;
            if (lat == 1) z_q <= 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n++;
        assert (o === e) else begin
            err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                in_data = d; in_last = l; in_valid = 1;
                @(negedge clk);
                in_valid = 0;
                return;
            end
        end
        chk("push_timeout", 0, 1);
    endtask

    task automatic wait_sum();
        for (int t = 0; t < 200; t++) begin
            if (sum_valid) return;
            @(negedge clk);
        end
        chk("sum_timeout", 0, 1);
    endtask

    task automatic get_sum(input string tag, input logic [31:0] d, input logic [CW-1:0] c);
        wait_sum();
        chk({tag, "_data"}, sum_data, d);
        chk({tag, "_count"}, 32'(sum_count), 32'(c));
        sum_ready = 1;
        @(negedge clk);
        sum_ready = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_a_stb"}, 32'(add_a_stb), 0);
        chk({tag, "_b_stb"}, 32'(add_b_stb), 0);
        chk({tag, "_z_ack"}, 32'(add_z_ack), 0);
        chk({tag, "_sum_valid"}, 32'(sum_valid), 0);
        chk({tag, "_add_a"}, add_a, 0);
        chk({tag, "_add_b"}, add_b, 0);
        chk({tag, "_sum_data"}, sum_data, 0);
        chk({tag, "_sum_count"}, 32'(sum_count), 0);
    endtask

    initial begin
        int a0, b0;
        bit seen;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 0;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 1);

        a0 = a_cnt; b0 = b_cnt;
        push(32'h3F800000, 0);
        push(32'h40000000, 0);
        push(32'h40400000, 1);
        wait_sum();
        chk("v1_a_xfers", a_cnt - a0, 3);
        chk("v1_b_xfers", b_cnt - b0, 3);
        in_data = 32'hC0490FDB; in_last = 1; in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            spur = i >= 3 && i < 6;
            chk("bp_data", sum_data, 32'h40C00000);
            chk("bp_count", 32'(sum_count), 3);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        spur = 0;
        sum_ready = 1;
        @(negedge clk);
        sum_ready = 0;
        chk("bp_released_valid", 32'(sum_valid), 0);
        chk("bp_released_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 0;
        chk("bp_accept_next", 32'(add_a_stb), 1);
        get_sum("single", 32'hC0490FDB, 1);

        push(32'h3F800000, 0);
        push(32'hBF800000, 1);
        get_sum("cancel", 32'h00000000, 2);

        push(32'h00000000, 0);
        push(32'h00000000, 0);
        push(32'h00000000, 0);
        push(32'h00000000, 0);
        push(32'h00000000, 1);
        get_sum("saturate", 32'h00000000, 3);

        push(32'h3F800000, 0);
        push(32'h40000000, 1);
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = add_z_ack && add_b == 32'h40000000;
        end
        chk("reach_wait_z", 32'(seen), 1);
        rst = 1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 0;
        push(32'h40000000, 1);
        get_sum("post_rst", 32'h40000000, 1);

        a0 = a_cnt; b0 = b_cnt;
        push(32'h00000000, 0);
        push(32'h80000000, 0);
        push(32'h3F800000, 1);
        get_sum("zero", 32'h3F800000, 3);
`ifdef FP_ACC_SKIP_ZERO_EN
        chk("zero_a_xfers", a_cnt - a0, 1);
        chk("zero_b_xfers", b_cnt - b0, 1);
`else
        chk("zero_a_xfers", a_cnt - a0, 3);
        chk("zero_b_xfers", b_cnt - b0, 3);
`endif
        @(negedge clk);
        chk("final_idle", 32'(in_ready), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n, err);
        $finish;
    end
endmodule
